keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Consumer side of the keypad scanner's keycode/keytrig interface.
- Detects each new key-trigger pulse and samples its 4-bit keycode.
- Assembles digit keys into a BCD entry buffer with backspace, clear and enter editing.
- Presents the committed number to downstream logic (DDS frequency/amplitude setup) through a valid/ready handshake.

Parameters:
- DIGITS, 4, BCD digits in the entry buffer (legal range 1..8)
- UNI, 1'b0, idle level of keytrig_i; the active level is ~UNI
- KEY_BKSP, 4'hD, keycode for backspace
- KEY_CLEAR, 4'hE, keycode for clear
- KEY_ENTER, 4'hF, keycode for enter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- keycode_i  in  4  scanner keycode; meaningful only while keytrig_i is active
- keytrig_i  in  1  scanner trigger pulse; idle = UNI, active = ~UNI for several cycles per press
- entry_o  out  4*DIGITS  live BCD buffer; digit 0 = [3:0] = most recent key
- count_o  out  $clog2(DIGITS+1)  number of digits currently entered
- value_o  out  4*DIGITS  committed BCD value
- valid_o  out  1  value_o is valid; held until accepted
- ready_i  in  1  downstream accepts value_o when valid_o && ready_i
- overflow_o  out  1  one-cycle pulse: digit key arrived with buffer full
- overrun_o  out  1  one-cycle pulse: enter replaced an unaccepted value

Behaviour:
- Reset: entry_o=0, count_o=0, value_o=0, valid_o=0, overflow_o=0, overrun_o=0.
- Reset loads the internal trigger-delay register with the active level (~UNI).
- A key held through reset therefore produces no event; the key must be released and pressed again.
- Event detection:
  - trig_d <= keytrig_i every cycle.
  - event = (keytrig_i==~UNI) && (trig_d==UNI).
  - Exactly one event per pulse, regardless of pulse length or a stuck-active trigger.
  - keycode_i is sampled only in the event cycle.
- Latency: all buffer and output updates occur on the same clock edge that samples the event. Effects are visible one cycle after keytrig_i is first seen active.
- Keycode 0x0..0x9 (digit):
  - If count<DIGITS: entry <= {entry[4*DIGITS-5:0], code}, count+1.
  - Otherwise: buffer unchanged and overflow_o pulses for 1 cycle.
- Keycode 0xA..0xC: ignored, no state change.
- KEY_BKSP:
  - If count>0: entry <= entry>>4, count-1.
  - If count==0: no-op.
- KEY_CLEAR: entry <= 0, count <= 0. value_o and valid_o are untouched.
- KEY_ENTER:
  - If count==0: ignored.
  - Otherwise: value_o <= entry, valid_o <= 1, entry <= 0, count <= 0.
- Handshake:
  - A transfer occurs on any cycle with valid_o && ready_i.
  - After a transfer, valid_o falls the next cycle unless a new enter loads on that same edge.
  - value_o is stable while valid_o=1 and not yet accepted.
- Enter while valid_o=1 and ready_i=0: value_o is overwritten, valid_o stays 1, overrun_o pulses for 1 cycle.
- Enter in the same cycle as an accepting transfer: the old value counts as transferred, the new value loads, valid_o stays 1, no overrun.
- Entry FSM (state derived from count, recorded for coverage):
  - EMPTY (count==0) -> ENTRY on a digit.
  - ENTRY -> FULL when count reaches DIGITS.
  - FULL -> ENTRY on backspace.
  - Any state -> EMPTY on clear, on enter with count>0, or on backspace from count==1.
- Width rules:
  - count saturates at DIGITS and never wraps.
  - Shifts are zero-filled.
  - No binary conversion is performed in this block.

Decomposition:
- Package keypad_pkg: UNI, KEY_BKSP/KEY_CLEAR/KEY_ENTER constants, digit-range check function.
- The scanner is updated to import UNI from keypad_pkg.
- One sub-module, keytrig_edge: trigger-delay register plus active-edge event output, with reset preset to active.

Test Plan:
- Press 1,2,3 then F, ready_i=1 -> value_o=16'h0123, valid_o high one cycle, entry_o=0, count_o=0.
- Press 9,8,7,6,5 (DIGITS=4) -> entry_o=16'h9876; overflow_o pulses once on the '5' event.
- Press 4,5,D,7, then E -> entry_o=16'h0047 after '7'; entry_o=0 and count_o=0 after E; D with count 0 is a no-op.
- Hold keytrig_i active 600 cycles with code 3 -> exactly one digit accepted, count_o=1.
- Enter 12 with ready_i=0, then enter 34 -> value_o=16'h0034, overrun_o pulses once, valid_o stays 1 until ready_i=1.
- Assert rst while keytrig_i is active -> all outputs 0; no event until keytrig_i returns to UNI and goes active again.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: trigger idle level, editing keycodes,
// entry-buffer state encoding and a digit-range helper.
// Imported by the scanner and by the entry consumer so both agree on UNI.
package keypad_pkg;

  // Idle level of the scanner trigger line; the active level is ~UNI.
  localparam logic UNI = 1'b0;

  // Editing keys on the 4x4 pad (digits occupy 0x0..0x9).
  localparam logic [3:0] KEY_BKSP  = 4'hD;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  // Entry buffer occupancy, derived from the digit count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } entry_state_t;

  // Decoded meaning of a sampled key event.
  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_DIGIT = 3'd1,
    K_BKSP  = 3'd2,
    K_CLEAR = 3'd3,
    K_ENTER = 3'd4
  } key_kind_t;

  // True for the decimal digit keys 0..9.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keytrig_edge.sv
// Purpose : turns the scanner's multi-cycle trigger pulse into a single-cycle event.
// Latency : combinational event in the first cycle the trigger is seen active.
// Ports   : clk, rst (sync, active-high), trig (scanner trigger), evt (event pulse).
module keytrig_edge #(
  parameter logic UNI = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic evt
);

  logic trig_d;

  // Reset presets the delay stage to the active level, so a key that is
  // already held when reset releases cannot produce an event; it must be
  // released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_d <= ~UNI;
    end else begin
      trig_d <= trig;
    end
  end

  assign evt = (trig == ~UNI) && (trig_d == UNI);

endmodule

// File: rtl/keypad_entry.sv
// Purpose : assembles keypad digits into a BCD entry buffer (backspace/clear/enter)
//           and offers the committed number downstream over valid/ready.
// Latency : every update lands on the edge that samples the key event (1 cycle).
// Backpressure: value_o/valid_o held until ready_i; a new enter overwrites an
//           unaccepted value and pulses overrun_o.
// Ports   : clk, rst (sync, active-high); keycode_i/keytrig_i from the scanner;
//           entry_o/count_o live buffer; value_o/valid_o/ready_i committed value;
//           overflow_o/overrun_o single-cycle status pulses.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int         DIGITS    = 4,
  parameter logic       UNI       = keypad_pkg::UNI,
  parameter logic [3:0] KEY_BKSP  = keypad_pkg::KEY_BKSP,
  parameter logic [3:0] KEY_CLEAR = keypad_pkg::KEY_CLEAR,
  parameter logic [3:0] KEY_ENTER = keypad_pkg::KEY_ENTER
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   keycode_i,
  input  logic                         keytrig_i,
  output logic [4*DIGITS-1:0]          entry_o,
  output logic [$clog2(DIGITS+1)-1:0]  count_o,
  output logic [4*DIGITS-1:0]          value_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         overflow_o,
  output logic                         overrun_o
);

  localparam int              W        = 4 * DIGITS;
  localparam int              CW       = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DIGITS);

  // --------------------------------------------------------------------------
  // Key event detection and decode
  // --------------------------------------------------------------------------
  logic evt;

  keytrig_edge #(
    .UNI (UNI)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .trig (keytrig_i),
    .evt  (evt)
  );

  key_kind_t kind;

  // keycode_i is only looked at in the event cycle; 0xA..0xC fall to K_NONE.
  always_comb begin
    kind = K_NONE;
    if (evt) begin
      if (is_digit(keycode_i)) begin
        kind = K_DIGIT;
      end else if (keycode_i == KEY_BKSP) begin
        kind = K_BKSP;
      end else if (keycode_i == KEY_CLEAR) begin
        kind = K_CLEAR;
      end else if (keycode_i == KEY_ENTER) begin
        kind = K_ENTER;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry FSM: occupancy state tracked alongside count, feeds full/empty
  // --------------------------------------------------------------------------
  entry_state_t state;
  entry_state_t state_nxt;
  logic         full;
  logic         empty;
  logic [CW-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // The next state follows the next count, which covers EMPTY->FULL
  // directly when the buffer holds a single digit.
  always_comb begin
    if (count_nxt == '0) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == FULL_CNT) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_ENTRY;
    end
  end

  always_comb begin
    full  = (state == ST_FULL);
    empty = (state == ST_EMPTY);
  end

  // --------------------------------------------------------------------------
  // Buffer, committed value and handshake
  // --------------------------------------------------------------------------
  logic [W-1:0] entry_nxt;
  logic [W-1:0] value_nxt;
  logic [W-1:0] code_ext;
  logic         load;
  logic         xfer;
  logic         valid_nxt;
  logic         overflow_nxt;
  logic         overrun_nxt;

  always_comb begin
    code_ext      = '0;
    code_ext[3:0] = keycode_i;

    entry_nxt    = entry_o;
    count_nxt    = count_o;
    value_nxt    = value_o;
    load         = 1'b0;
    overflow_nxt = 1'b0;

    case (kind)
      K_DIGIT: begin
        if (!full) begin
          // Newest digit enters at the bottom nibble; zero-filled shift.
          entry_nxt = (entry_o << 4) | code_ext;
          count_nxt = count_o + 1'b1;
        end else begin
          overflow_nxt = 1'b1;
        end
      end
      K_BKSP: begin
        if (!empty) begin
          entry_nxt = entry_o >> 4;
          count_nxt = count_o - 1'b1;
        end
      end
      K_CLEAR: begin
        entry_nxt = '0;
        count_nxt = '0;
      end
      K_ENTER: begin
        if (!empty) begin
          value_nxt = entry_o;
          load      = 1'b1;
          entry_nxt = '0;
          count_nxt = '0;
        end
      end
      default: begin
      end
    endcase

    // A transfer on the same edge as a load retires the old value and the
    // new one takes its place, so valid stays high with no overrun.
    xfer        = valid_o & ready_i;
    valid_nxt   = load | (valid_o & ~xfer);
    overrun_nxt = load & valid_o & ~ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_o    <= '0;
      count_o    <= '0;
      value_o    <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      entry_o    <= entry_nxt;
      count_o    <= count_nxt;
      value_o    <= value_nxt;
      valid_o    <= valid_nxt;
      overflow_o <= overflow_nxt;
      overrun_o  <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios with literal expectations plus
// randomized key presses and ready toggling against a queue-based model.
module tb_keypad_entry;

  localparam int   DIGITS = 4;
  localparam logic UNI    = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  keycode;
  logic        keytrig;
  logic        ready;
  logic [15:0] entry;
  logic [2:0]  count;
  logic [15:0] value;
  logic        valid;
  logic        overflow;
  logic        overrun;

  always #5 clk = ~clk;

  keypad_entry #(
    .DIGITS    (DIGITS),
    .UNI       (UNI),
    .KEY_BKSP  (4'hD),
    .KEY_CLEAR (4'hE),
    .KEY_ENTER (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keycode_i  (keycode),
    .keytrig_i  (keytrig),
    .entry_o    (entry),
    .count_o    (count),
    .value_o    (value),
    .valid_o    (valid),
    .ready_i    (ready),
    .overflow_o (overflow),
    .overrun_o  (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: digits held in a queue, oldest first.
  // ---------------------------------------------------------------------------
  int          q[$];
  logic [15:0] m_value;
  bit          m_valid;
  bit          m_ovf;
  bit          m_ovr;
  logic        m_prev;
  bit          chk_en = 1'b0;

  function automatic logic [15:0] q_bcd();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < q.size(); i++)
      r = r | (16'(q[q.size()-1-i]) << (4*i));
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit ev;
    bit xfer;
    bit load;
    if (rst) begin
      q.delete();
      m_value = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_ovr   = 1'b0;
      m_prev  = ~UNI;
      chk_en  = 1'b1;
    end else begin
      ev     = (keytrig == ~UNI) && (m_prev == UNI);
      m_prev = keytrig;
      xfer   = m_valid && ready;
      load   = 1'b0;
      m_ovf  = 1'b0;
      m_ovr  = 1'b0;
      if (ev) begin
        if (keycode <= 4'd9) begin
          if (q.size() < DIGITS) q.push_back(int'(keycode));
          else m_ovf = 1'b1;
        end else if (keycode == 4'hD) begin
          if (q.size() > 0) void'(q.pop_back());
        end else if (keycode == 4'hE) begin
          q.delete();
        end else if (keycode == 4'hF) begin
          if (q.size() > 0) begin
            if (m_valid && !ready) m_ovr = 1'b1;
            m_value = q_bcd();
            q.delete();
            load = 1'b1;
          end
        end
      end
      m_valid = load ? 1'b1 : (xfer ? 1'b0 : m_valid);
    end
  end

  // Pulse/valid tallies used by directed checks.
  int ovf_cnt = 0;
  int ovr_cnt = 0;
  int vld_cnt = 0;

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("entry",    32'(entry),    32'(q_bcd()));
      check("count",    32'(count),    32'(q.size()));
      check("value",    32'(value),    32'(m_value));
      check("valid",    32'(valid),    32'(m_valid));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("overrun",  32'(overrun),  32'(m_ovr));
      if (overflow) ovf_cnt++;
      if (overrun)  ovr_cnt++;
      if (valid)    vld_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit rand_ready = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  // Keycode is scrambled after the first active cycle: only the event
  // cycle's code may matter.
  task automatic press(input logic [3:0] code, input int hold, input int gap);
    keytrig = ~UNI;
    keycode = code;
    tick();
    for (int i = 1; i < hold; i++) begin
      keycode = 4'($urandom);
      tick();
    end
    keytrig = UNI;
    keycode = 4'($urandom);
    for (int i = 0; i < gap; i++) tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int base2;
    rst     = 1'b1;
    keytrig = UNI;
    keycode = 4'h0;
    ready   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_entry",    32'(entry),    32'h0);
    check("rst_count",    32'(count),    32'h0);
    check("rst_value",    32'(value),    32'h0);
    check("rst_valid",    32'(valid),    32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_overrun",  32'(overrun),  32'h0);

    // 1,2,3,enter with ready high
    ready = 1'b1;
    base  = vld_cnt;
    press(4'h1, 2, 2);
    press(4'h2, 3, 1);
    press(4'h3, 1, 2);
    check("d1_entry_pre", 32'(entry), 32'h0123);
    press(4'hF, 2, 2);
    check("d1_value",       32'(value),     32'h0123);
    check("d1_model_value", 32'(m_value),   32'h0123);
    check("d1_entry",       32'(entry),     32'h0);
    check("d1_count",       32'(count),     32'h0);
    check("d1_valid_cyc",   32'(vld_cnt - base), 32'd1);

    // Overflow on the fifth digit
    base = ovf_cnt;
    press(4'h9, 2, 1);
    press(4'h8, 2, 1);
    press(4'h7, 2, 1);
    press(4'h6, 2, 1);
    press(4'h5, 2, 2);
    check("d2_entry",       32'(entry),  32'h9876);
    check("d2_model_entry", 32'(q_bcd()), 32'h9876);
    check("d2_count",       32'(count),  32'd4);
    check("d2_ovf_pulses",  32'(ovf_cnt - base), 32'd1);
    press(4'hE, 2, 2);

    // Backspace editing and clear
    press(4'hD, 2, 2);
    check("d3_bksp_empty_count", 32'(count), 32'h0);
    check("d3_bksp_empty_entry", 32'(entry), 32'h0);
    press(4'h4, 2, 1);
    press(4'h5, 2, 1);
    press(4'hD, 2, 1);
    press(4'h7, 2, 2);
    check("d3_entry", 32'(entry), 32'h0047);
    check("d3_count", 32'(count), 32'd2);
    press(4'hE, 2, 2);
    check("d3_clr_entry", 32'(entry), 32'h0);
    check("d3_clr_count", 32'(count), 32'h0);
    check("d3_clr_value", 32'(value), 32'h0123);

    // Long press counts once
    press(4'h3, 600, 2);
    check("d4_count", 32'(count), 32'd1);
    check("d4_entry", 32'(entry), 32'h0003);
    press(4'hE, 2, 2);

    // Overrun with downstream stalled
    ready = 1'b0;
    base  = ovr_cnt;
    press(4'h1, 2, 1);
    press(4'h2, 2, 1);
    press(4'hF, 2, 2);
    check("d5_value1", 32'(value), 32'h0012);
    check("d5_valid1", 32'(valid), 32'h1);
    press(4'h3, 2, 1);
    press(4'h4, 2, 1);
    press(4'hF, 2, 3);
    check("d5_value2",     32'(value), 32'h0034);
    check("d5_valid2",     32'(valid), 32'h1);
    check("d5_ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    base2 = vld_cnt;
    ready = 1'b1;
    tick();
    tick();
    check("d5_valid_drop", 32'(valid), 32'h0);
    check("d5_valid_cyc",  32'(vld_cnt - base2), 32'd1);

    // Reset with the key held
    press(4'h5, 2, 2);
    keytrig = ~UNI;
    keycode = 4'h6;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("d6_entry", 32'(entry), 32'h0);
    check("d6_count", 32'(count), 32'h0);
    check("d6_value", 32'(value), 32'h0);
    check("d6_valid", 32'(valid), 32'h0);
    keytrig = UNI;
    tick();
    press(4'h7, 2, 2);
    check("d6_count_after", 32'(count), 32'd1);
    check("d6_entry_after", 32'(entry), 32'h0007);

    // Randomized presses with random ready
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      press(c, $urandom_range(1, 6), $urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
